// File: rtl/lsu_bus_ctrl.sv
// Load/store bus controller: turns a decoded RV32I load/store into one valid/ready
// request plus optional read response, stalling the core until the access retires.
module lsu_bus_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        misaligned,
    output logic [31:0] rdata,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rsp_data,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 32'd1);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [7:0]  cnt_r;
    logic        access_s;
    logic        misaligned_s;
    logic        start_s;
    logic        last_s;
    logic        tmo_s;

    logic        bus_req_valid_r;
    logic        bus_we_r;
    logic [31:0] bus_addr_r;
    logic [3:0]  bus_wstrb_r;
    logic [31:0] bus_wdata_r;
    logic [31:0] rdata_r;
    logic        bus_err_r;

    function automatic logic [3:0] strobe_f(input logic [1:0] sz, input logic [1:0] lo);
        case (sz)
            2'b00:   strobe_f = 4'b0001 << lo;
            2'b01:   strobe_f = 4'b0011 << {lo[1], 1'b0};
            default: strobe_f = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lanes_f(input logic [1:0] sz, input logic [31:0] wd);
        case (sz)
            2'b00:   lanes_f = {4{wd[7:0]}};
            2'b01:   lanes_f = {2{wd[15:0]}};
            default: lanes_f = wd;
        endcase
    endfunction

    // Access decode and natural-alignment check (size 11 behaves as word)
    always_comb begin
        access_s = mem_read | mem_write;
        if (size == 2'b01) begin
            misaligned_s = access_s & addr[0];
        end else if (size[1]) begin
            misaligned_s = access_s & (addr[1:0] != 2'b00);
        end else begin
            misaligned_s = 1'b0;
        end
    end

    // Next-state logic; completion on the last allowed cycle beats the timeout
    always_comb begin
        state_nxt_s = state_r;
        start_s     = 1'b0;
        tmo_s       = 1'b0;
        last_s      = (cnt_r >= CNT_LAST);
        case (state_r)
            ST_IDLE: begin
                if (access_s && !misaligned_s) begin
                    start_s     = 1'b1;
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bus_req_ready) begin
                    state_nxt_s = bus_we_r ? ST_DONE : ST_RESP;
                end else if (last_s) begin
                    tmo_s       = 1'b1;
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_RESP: begin
                if (bus_rsp_valid) begin
                    state_nxt_s = ST_DONE;
                end else if (last_s) begin
                    tmo_s       = 1'b1;
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register and REQ/RESP cycle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 8'd0;
        end else begin
            state_r <= state_nxt_s;
            if (start_s) begin
                cnt_r <= 8'd0;
            end else if (((state_r == ST_REQ) || (state_r == ST_RESP)) && (cnt_r != 8'hFF)) begin
                cnt_r <= cnt_r + 8'd1;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Request fields are captured only when a new access leaves IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_req_valid_r <= 1'b0;
            bus_we_r        <= 1'b0;
            bus_addr_r      <= 32'd0;
            bus_wstrb_r     <= 4'd0;
            bus_wdata_r     <= 32'd0;
        end else begin
            bus_req_valid_r <= (state_nxt_s == ST_REQ);
            if (start_s) begin
                bus_we_r    <= mem_write;
                bus_addr_r  <= {addr[31:2], 2'b00};
                bus_wstrb_r <= mem_write ? strobe_f(size, addr[1:0]) : 4'b0000;
                bus_wdata_r <= lanes_f(size, wdata);
            end
        end
    end

    // Read data capture and one-cycle timeout flag
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r   <= 32'd0;
            bus_err_r <= 1'b0;
        end else begin
            bus_err_r <= tmo_s;
            if ((state_r == ST_RESP) && bus_rsp_valid) begin
                rdata_r <= bus_rsp_data;
            end else if (tmo_s) begin
                rdata_r <= 32'd0;
            end
        end
    end

    assign stall         = start_s | (state_r == ST_REQ) | (state_r == ST_RESP);
    assign misaligned    = misaligned_s;
    assign rdata         = rdata_r;
    assign bus_req_valid = bus_req_valid_r;
    assign bus_we        = bus_we_r;
    assign bus_addr      = bus_addr_r;
    assign bus_wstrb     = bus_wstrb_r;
    assign bus_wdata     = bus_wdata_r;
    assign bus_err       = bus_err_r;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Bench for lsu_bus_ctrl: two instances (TIMEOUT 16 and 4) checked cycle by cycle
// against a per-transaction timeline predicted from handshake delays.
module tb_lsu_bus_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [1:0]       mem_read, mem_write, ready, rsp_valid;
    logic [1:0][1:0]  size;
    logic [1:0][31:0] addr, wdata, rsp_data;
    logic [1:0]       stall, misaligned, req_valid, bus_we, bus_err;
    logic [1:0][31:0] rdata, bus_addr, bus_wdata;
    logic [1:0][3:0]  bus_wstrb;

    lsu_bus_ctrl #(.TIMEOUT(16)) dut0 (
        .clk(clk), .rst(rst), .mem_read(mem_read[0]), .mem_write(mem_write[0]),
        .size(size[0]), .addr(addr[0]), .wdata(wdata[0]), .stall(stall[0]),
        .misaligned(misaligned[0]), .rdata(rdata[0]), .bus_req_valid(req_valid[0]),
        .bus_req_ready(ready[0]), .bus_we(bus_we[0]), .bus_addr(bus_addr[0]),
        .bus_wstrb(bus_wstrb[0]), .bus_wdata(bus_wdata[0]), .bus_rsp_valid(rsp_valid[0]),
        .bus_rsp_data(rsp_data[0]), .bus_err(bus_err[0])
    );

    lsu_bus_ctrl #(.TIMEOUT(4)) dut1 (
        .clk(clk), .rst(rst), .mem_read(mem_read[1]), .mem_write(mem_write[1]),
        .size(size[1]), .addr(addr[1]), .wdata(wdata[1]), .stall(stall[1]),
        .misaligned(misaligned[1]), .rdata(rdata[1]), .bus_req_valid(req_valid[1]),
        .bus_req_ready(ready[1]), .bus_we(bus_we[1]), .bus_addr(bus_addr[1]),
        .bus_wstrb(bus_wstrb[1]), .bus_wdata(bus_wdata[1]), .bus_rsp_valid(rsp_valid[1]),
        .bus_rsp_data(rsp_data[1]), .bus_err(bus_err[1])
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] m_rdata [2];
    logic [31:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    logic [3:0]  m_strb  [2];
    logic        m_we    [2];

    typedef struct {
        int          d;
        bit          re;
        bit          we;
        logic [1:0]  sz;
        logic [31:0] a;
        logic [31:0] wd;
        int          r;
        int          p;
        logic [31:0] rsp;
        int          e_stall;
        logic [31:0] e_addr;
        logic [3:0]  e_strb;
        logic [31:0] e_wdata;
        logic        e_err;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d: got %h expected %h (t=%0t)", nm, d, act, exp, $time);
    endtask

    task automatic chk_cycle(input int d, input logic e_stall, input logic e_mis,
                             input logic e_req, input logic e_err);
        chk("stall",      d, 32'(stall[d]),      32'(e_stall));
        chk("misaligned", d, 32'(misaligned[d]), 32'(e_mis));
        chk("req_valid",  d, 32'(req_valid[d]),  32'(e_req));
        chk("bus_err",    d, 32'(bus_err[d]),    32'(e_err));
        chk("bus_we",     d, 32'(bus_we[d]),     32'(m_we[d]));
        chk("bus_addr",   d, bus_addr[d],        m_addr[d]);
        chk("bus_wstrb",  d, 32'(bus_wstrb[d]),  32'(m_strb[d]));
        chk("bus_wdata",  d, bus_wdata[d],       m_wdata[d]);
        chk("rdata",      d, rdata[d],           m_rdata[d]);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            m_rdata[i] = 32'd0; m_addr[i] = 32'd0; m_wdata[i] = 32'd0;
            m_strb[i] = 4'd0; m_we[i] = 1'b0;
        end
    endtask

    // r = REQ cycles without ready before it rises; p = RESP cycles without rsp_valid
    task automatic run_txn(input int d, input bit re, input bit we, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] wd, input int r,
                           input int p, input logic [31:0] rsp, output int scnt);
        int T = (d == 1) ? 4 : 16;
        int nb, reqn, busy, e, lim;
        bit acc, mis, tmo;
        acc  = re | we;
        nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        mis  = acc && ((int'(a[1:0]) % nb) != 0);
        scnt = 0;
        @(negedge clk);
        mem_read[1-d] = 1'b0; mem_write[1-d] = 1'b0;
        mem_read[d] = re; mem_write[d] = we; size[d] = sz; addr[d] = a; wdata[d] = wd;
        ready[d] = 1'($urandom); rsp_valid[d] = 1'($urandom); rsp_data[d] = $urandom;
        #1;
        if (!acc || mis) begin
            chk_cycle(d, 1'b0, mis, 1'b0, 1'b0);
            return;
        end
        chk_cycle(d, 1'b1, 1'b0, 1'b0, 1'b0);
        scnt += int'(stall[d]);
        reqn = ((r < T - 1) ? r : T - 1) + 1;
        tmo  = 1'b0;
        if (r > T - 1) begin
            busy = T; tmo = 1'b1;
        end else if (we) begin
            busy = r + 1;
        end else begin
            e   = r + 1 + p;
            lim = (T - 1 > r + 1) ? T - 1 : r + 1;
            if (e <= lim) busy = e + 1;
            else begin busy = lim + 1; tmo = 1'b1; end
        end
        m_addr[d] = {a[31:2], 2'b00};
        m_we[d]   = we;
        m_strb[d] = !we ? 4'b0000 : (nb == 4) ? 4'b1111 :
                    (nb == 2) ? (a[1] ? 4'b1100 : 4'b0011) : (4'b0001 << a[1:0]);
        m_wdata[d] = (nb == 1) ? {4{wd[7:0]}} : (nb == 2) ? {2{wd[15:0]}} : wd;
        for (int i = 0; i < busy; i++) begin
            @(negedge clk);
            ready[d]     = (i < reqn) ? (i == r) : 1'($urandom);
            rsp_valid[d] = (i >= reqn && !we) ? (i == r + 1 + p) : 1'($urandom);
            rsp_data[d]  = (i == r + 1 + p) ? rsp : $urandom;
            #1;
            chk_cycle(d, 1'b1, 1'b0, (i < reqn), 1'b0);
            scnt += int'(stall[d]);
        end
        if (tmo) m_rdata[d] = 32'd0;
        else if (!we) m_rdata[d] = rsp;
        @(negedge clk);
        ready[d] = 1'($urandom); rsp_valid[d] = 1'($urandom); rsp_data[d] = $urandom;
        #1;
        chk_cycle(d, 1'b0, 1'b0, 1'b0, tmo);
        scnt += int'(stall[d]);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int sc, T, sel;
        bit re, we;
        rst = 1'b1;
        mem_read = 2'b00; mem_write = 2'b00; ready = 2'b00; rsp_valid = 2'b00;
        size = '0; addr = '0; wdata = '0; rsp_data = '0;
        model_clear();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk_cycle(0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_cycle(1, 1'b0, 1'b0, 1'b0, 1'b0);

        //            d re we sz     addr          wdata         r    p    rsp           stl addr          strb     wdata         err   rdata
        tbl[0]  = '{0, 0, 1, 2'd0, 32'h0000_1003, 32'hAABB_CCDD, 0,   0,   32'h0,        2, 32'h0000_1000, 4'b1000, 32'hDDDD_DDDD, 1'b0, 32'h0};
        tbl[1]  = '{0, 1, 0, 2'd2, 32'h0000_2000, 32'h0,         2,   2,   32'h1234_5678, 7, 32'h0000_2000, 4'b0000, 32'h0,         1'b0, 32'h1234_5678};
        tbl[2]  = '{0, 1, 0, 2'd1, 32'h0000_3001, 32'h0,         0,   0,   32'h0,        0, 32'h0000_2000, 4'b0000, 32'h0,         1'b0, 32'h1234_5678};
        tbl[3]  = '{0, 0, 1, 2'd2, 32'h0000_3002, 32'h55,        0,   0,   32'h0,        0, 32'h0000_2000, 4'b0000, 32'h0,         1'b0, 32'h1234_5678};
        tbl[4]  = '{0, 0, 1, 2'd2, 32'h0000_2000, 32'hA5A5_0F0F, 1,   0,   32'h0,        3, 32'h0000_2000, 4'b1111, 32'hA5A5_0F0F, 1'b0, 32'h1234_5678};
        tbl[5]  = '{0, 1, 0, 2'd2, 32'h0000_2000, 32'h0,         0,   0,   32'h0BAD_F00D, 3, 32'h0000_2000, 4'b0000, 32'h0,         1'b0, 32'h0BAD_F00D};
        tbl[6]  = '{0, 1, 1, 2'd3, 32'h0000_0010, 32'h1122_3344, 0,   0,   32'h0,        2, 32'h0000_0010, 4'b1111, 32'h1122_3344, 1'b0, 32'h0BAD_F00D};
        tbl[7]  = '{0, 0, 1, 2'd1, 32'h0000_0006, 32'h0000_BEEF, 0,   0,   32'h0,        2, 32'h0000_0004, 4'b1100, 32'hBEEF_BEEF, 1'b0, 32'h0BAD_F00D};
        tbl[8]  = '{1, 1, 0, 2'd2, 32'h0000_0048, 32'h0,         1,   0,   32'hCAFE_F00D, 4, 32'h0000_0048, 4'b0000, 32'h0,         1'b0, 32'hCAFE_F00D};
        tbl[9]  = '{1, 1, 0, 2'd2, 32'h0000_0040, 32'h0,         0,   100, 32'h0,        5, 32'h0000_0040, 4'b0000, 32'h0,         1'b1, 32'h0};
        tbl[10] = '{1, 0, 1, 2'd0, 32'h0000_0041, 32'h77,        0,   0,   32'h0,        2, 32'h0000_0040, 4'b0010, 32'h7777_7777, 1'b0, 32'h0};
        tbl[11] = '{1, 1, 0, 2'd2, 32'h0000_004C, 32'h0,         0,   0,   32'h1357_9BDF, 3, 32'h0000_004C, 4'b0000, 32'h0,         1'b0, 32'h1357_9BDF};
        tbl[12] = '{1, 0, 1, 2'd2, 32'h0000_0050, 32'hFFFF_0000, 100, 0,   32'h0,        5, 32'h0000_0050, 4'b1111, 32'hFFFF_0000, 1'b1, 32'h0};
        tbl[13] = '{1, 1, 0, 2'd0, 32'h0000_0053, 32'h0,         2,   0,   32'h2468_1357, 5, 32'h0000_0050, 4'b0000, 32'h0,         1'b0, 32'h2468_1357};

        for (int k = 0; k < 14; k++) begin
            run_txn(tbl[k].d, tbl[k].re, tbl[k].we, tbl[k].sz, tbl[k].a, tbl[k].wd,
                    tbl[k].r, tbl[k].p, tbl[k].rsp, sc);
            chk($sformatf("vec%0d stall_cycles", k), tbl[k].d, 32'(sc), 32'(tbl[k].e_stall));
            chk($sformatf("vec%0d bus_addr", k),  tbl[k].d, bus_addr[tbl[k].d],  tbl[k].e_addr);
            chk($sformatf("vec%0d bus_wstrb", k), tbl[k].d, 32'(bus_wstrb[tbl[k].d]), 32'(tbl[k].e_strb));
            chk($sformatf("vec%0d bus_wdata", k), tbl[k].d, bus_wdata[tbl[k].d], tbl[k].e_wdata);
            chk($sformatf("vec%0d bus_err", k),   tbl[k].d, 32'(bus_err[tbl[k].d]), 32'(tbl[k].e_err));
            chk($sformatf("vec%0d rdata", k),     tbl[k].d, rdata[tbl[k].d],     tbl[k].e_rdata);
        end

        for (int d = 0; d < 2; d++) begin
            T = (d == 1) ? 4 : 16;
            for (int n = 0; n < 60; n++) begin
                sel = int'($urandom_range(0, 3));
                re  = (sel == 1) || (sel == 3);
                we  = (sel == 2) || (sel == 3);
                run_txn(d, re, we, 2'($urandom), $urandom, $urandom,
                        int'($urandom_range(0, T + 1)), int'($urandom_range(0, T + 1)),
                        $urandom, sc);
            end
        end

        // Reset while waiting for a read response
        @(negedge clk);
        mem_read[1] = 1'b0; mem_write[1] = 1'b0;
        mem_read[0] = 1'b1; mem_write[0] = 1'b0; size[0] = 2'd2; addr[0] = 32'h50; wdata[0] = 32'h0;
        ready[0] = 1'b0; rsp_valid[0] = 1'b0;
        #1;
        chk_cycle(0, 1'b1, 1'b0, 1'b0, 1'b0);
        m_addr[0] = 32'h50; m_we[0] = 1'b0; m_strb[0] = 4'd0; m_wdata[0] = 32'h0;
        @(negedge clk);
        ready[0] = 1'b1;
        #1;
        chk_cycle(0, 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        ready[0] = 1'b0; rst = 1'b1;
        #1;
        chk_cycle(0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0; mem_read[0] = 1'b0;
        model_clear();
        #1;
        chk_cycle(0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_cycle(1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rsp_valid[0] = 1'b1; rsp_data[0] = 32'hDEAD_BEEF ^ i;
            #1;
            chk_cycle(0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
